fir_tap_buffer: RTL and testbench
=================================

Name: fir_tap_buffer

Overview:
- Multi-channel sample delay line for time-multiplexed FIR datapaths.
- Stores the last NUM_COEF input samples per channel in circular buffers.
- On each accepted sample, streams taps x[n], x[n-1] … x[n-NUM_COEF+1] of that channel, one per clock, to the MAC stage.
- Replaces the single-channel shift-register/mux delay line. Adds channels, a valid/ready handshake, automatic tap sequencing and reset.

Parameters:
- WIN, 16, sample width in bits (two's complement, passed through unmodified).
- NUM_COEF, 17, taps per channel; any value ≥ 2, not required to be a power of 2.
- NUM_CH, 2, number of independent channels; ≥ 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  WIN  input sample (signed).
- din_ch  in  CW=max(1,log2(NUM_CH))  channel of din.
- din_valid  in  1  din/din_ch valid.
- din_ready  out  1  block can accept a sample.
- dout  out  WIN  tap sample (signed).
- dout_tap  out  TW=log2(NUM_COEF)  tap index k of dout.
- dout_ch  out  CW  channel of dout.
- dout_valid  out  1  dout beat valid.
- dout_last  out  1  final beat of the current scan.

Behaviour:
- Reset (rst_n low, async):
  - All buffer entries = 0; all write pointers = 0; FSM = IDLE; tap counter = 0.
  - dout = 0, dout_tap = 0, dout_ch = 0, dout_valid = 0, dout_last = 0.
  - din_ready = 1 once rst_n is high.
- Storage: NUM_CH × NUM_COEF × WIN registers; one write pointer wp[c] per channel, range 0..NUM_COEF-1.
- FSM states: IDLE, SCAN. din_ready = (state == IDLE), combinational from state only.
- IDLE, on accept (din_valid & din_ready at edge E0):
  - If din_ch < NUM_CH: buf[din_ch][wp[din_ch]] ← din; base ← wp[din_ch]; ch_l ← din_ch; wp[din_ch] ← (wp == NUM_COEF-1) ? 0 : wp+1; cnt ← 0; state → SCAN.
  - If din_ch ≥ NUM_CH: sample is consumed and dropped. No write, no scan, state stays IDLE.
- SCAN, each edge:
  - dout ← buf[ch_l][(base − cnt) mod NUM_COEF]. The wrap is done by adding NUM_COEF when base < cnt; no power-of-2 masking.
  - dout_tap ← cnt; dout_ch ← ch_l; dout_valid ← 1; dout_last ← (cnt == SCAN_LEN-1); cnt ← cnt+1.
  - When cnt == SCAN_LEN-1: state → IDLE.
- SCAN_LEN = NUM_COEF.
- Latency and throughput:
  - Beat k appears after edge E(k+1).
  - Tap 0 is the sample written at E0; the write is visible to the E1 read.
  - din_ready returns high during the cycle showing dout_last, so a new sample can be accepted on the edge that ends the last beat.
  - Max rate: one sample per SCAN_LEN+1 clocks.
- IDLE without accept: dout_valid ← 0, dout_last ← 0. dout, dout_tap and dout_ch hold.
- din_valid during SCAN is ignored (not accepted). The source must hold it, per valid/ready rules.
- Untouched channels' buffers and pointers are never modified by other channels' traffic.
- Reset asserted mid-scan:
  - Scan aborts immediately; dout_valid drops asynchronously.
  - History is cleared, so the next scan shows zeros for taps ≥ 1.
- No backpressure on dout: the consumer must take every beat while dout_valid = 1.

Optional Feature:
- Macro: FIR_TAP_BUFFER_SYM_EN.
- Defined:
  - Adds output port dout_mirror (WIN) for symmetric, linear-phase FIRs; SCAN_LEN = ceil(NUM_COEF/2).
  - Beat k: dout = tap k, dout_mirror = tap NUM_COEF-1-k.
  - For odd NUM_COEF, the middle beat (k == NUM_COEF/2) has dout_mirror = 0, so a pre-adder sees the centre tap once.
  - dout_mirror resets to 0 and holds in IDLE like dout.
- Undefined: port absent; SCAN_LEN = NUM_COEF.

Test Plan:
1. Reset; ch0 accepts 0x0001 → 17 beats, tap0 = 0x0001, taps 1–16 = 0x0000, dout_last only on tap 16, din_ready low for 17 cycles after accept.
2. ch0 samples 1..20 back-to-back at max rate → after the 20th, beat k = 20−k for k = 0..16; checks pointer wrap at 17 and that no beat is lost between scans.
3. Interleave ch0 = 0x1000+i and ch1 = 0x2000+i for i = 0..9 → every ch0 scan contains only 0x1xxx values, every ch1 scan only 0x2xxx values; dout_ch matches.
4. Sample 0x8000 (most negative), then 0x7FFF on ch1 → taps reproduce exact bit patterns; din_ch = 2 with NUM_CH = 2 → no dout_valid, ch0/ch1 history unchanged.
5. Assert rst_n low at beat 5 of a scan → dout_valid = 0 with no clock edge; next ch0 sample 0x0003 → tap0 = 0x0003, all other taps 0.
6. FIR_TAP_BUFFER_SYM_EN, NUM_COEF = 17, ch0 samples 1..17 → 9 beats, beat k: dout = 17−k, dout_mirror = 1+k for k < 8; beat 8: dout = 9, dout_mirror = 0, dout_last = 1.

Source files
------------

// File: rtl/fir_tap_buffer_if.sv
// Sample-in / tap-out bundle of the multi-channel FIR delay line.
// dout_mirror exists only when FIR_TAP_BUFFER_SYM_EN is defined.
interface fir_tap_buffer_if #(
    parameter int unsigned WIN      = 16,
    parameter int unsigned NUM_COEF = 17,
    parameter int unsigned NUM_CH   = 2
);
    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned TW = $clog2(NUM_COEF);

    logic signed [WIN-1:0] din;
    logic [CW-1:0]         din_ch;
    logic                  din_valid;
    logic                  din_ready;
    logic signed [WIN-1:0] dout;
    logic [TW-1:0]         dout_tap;
    logic [CW-1:0]         dout_ch;
    logic                  dout_valid;
    logic                  dout_last;
`ifdef FIR_TAP_BUFFER_SYM_EN
    logic signed [WIN-1:0] dout_mirror;

    modport master (
        output din, din_ch, din_valid,
        input  din_ready, dout, dout_tap, dout_ch, dout_valid, dout_last, dout_mirror
    );
    modport slave (
        input  din, din_ch, din_valid,
        output din_ready, dout, dout_tap, dout_ch, dout_valid, dout_last, dout_mirror
    );
`else
    modport master (
        output din, din_ch, din_valid,
        input  din_ready, dout, dout_tap, dout_ch, dout_valid, dout_last
    );
    modport slave (
        input  din, din_ch, din_valid,
        output din_ready, dout, dout_tap, dout_ch, dout_valid, dout_last
    );
`endif
endinterface

// File: rtl/fir_tap_buffer.sv
// Multi-channel circular-buffer delay line streaming x[n]..x[n-NUM_COEF+1] per accepted sample.
// FIR_TAP_BUFFER_SYM_EN: half-length scans with a mirrored tap output for symmetric FIRs.
module fir_tap_buffer #(
    parameter int unsigned WIN      = 16,
    parameter int unsigned NUM_COEF = 17,
    parameter int unsigned NUM_CH   = 2
) (
    input logic             clk,
    input logic             rst_n,
    fir_tap_buffer_if.slave tap_if
);
    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned TW = $clog2(NUM_COEF);
`ifdef FIR_TAP_BUFFER_SYM_EN
    localparam int unsigned SCAN_LEN = (NUM_COEF + 1) / 2;
`else
    localparam int unsigned SCAN_LEN = NUM_COEF;
`endif

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e         state_q;
    logic [WIN-1:0] mem_q [NUM_CH][NUM_COEF];
    logic [TW-1:0]  wp_q  [NUM_CH];
    logic [TW-1:0]  base_q;
    logic [TW-1:0]  cnt_q;
    logic [CW-1:0]  ch_q;
    logic [WIN-1:0] dout_q;
    logic [TW-1:0]  dout_tap_q;
    logic [CW-1:0]  dout_ch_q;
    logic           dout_valid_q;
    logic           dout_last_q;

    logic           ch_ok;
    logic [TW:0]    rd_sum;
    logic [TW-1:0]  rd_idx;

    // Out-of-range channels are consumed but never touch storage.
    assign ch_ok = 32'(tap_if.din_ch) < NUM_CH;

    // (base - cnt) mod NUM_COEF without power-of-2 masking.
    always_comb begin
        rd_sum = '0;
        if (base_q >= cnt_q) begin
            rd_sum = {1'b0, base_q} - {1'b0, cnt_q};
        end else begin
            rd_sum = {1'b0, base_q} + (TW+1)'(NUM_COEF) - {1'b0, cnt_q};
        end
        rd_idx = rd_sum[TW-1:0];
    end

`ifdef FIR_TAP_BUFFER_SYM_EN
    logic [WIN-1:0] dout_mirror_q;
    logic [TW:0]    mr_sum;
    logic [TW-1:0]  mr_idx;
    logic           is_mid;

    // Tap NUM_COEF-1-k sits at (base + 1 + k) mod NUM_COEF.
    always_comb begin
        mr_sum = {1'b0, base_q} + (TW+1)'(1) + {1'b0, cnt_q};
        if (mr_sum >= (TW+1)'(NUM_COEF)) begin
            mr_sum = mr_sum - (TW+1)'(NUM_COEF);
        end
        mr_idx = mr_sum[TW-1:0];
        is_mid = ((NUM_COEF % 2) == 1) && (cnt_q == TW'(NUM_COEF / 2));
    end

    assign tap_if.dout_mirror = dout_mirror_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            base_q       <= '0;
            cnt_q        <= '0;
            ch_q         <= '0;
            dout_q       <= '0;
            dout_tap_q   <= '0;
            dout_ch_q    <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
`ifdef FIR_TAP_BUFFER_SYM_EN
            dout_mirror_q <= '0;
`endif
            for (int c = 0; c < int'(NUM_CH); c++) begin
                wp_q[c] <= '0;
                for (int t = 0; t < int'(NUM_COEF); t++) begin
                    mem_q[c][t] <= '0;
                end
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    dout_valid_q <= 1'b0;
                    dout_last_q  <= 1'b0;
                    if (tap_if.din_valid && ch_ok) begin
                        mem_q[tap_if.din_ch][wp_q[tap_if.din_ch]] <= tap_if.din;
                        base_q <= wp_q[tap_if.din_ch];
                        ch_q   <= tap_if.din_ch;
                        wp_q[tap_if.din_ch] <= (wp_q[tap_if.din_ch] == TW'(NUM_COEF - 1)) ?
                                               '0 : wp_q[tap_if.din_ch] + TW'(1);
                        cnt_q   <= '0;
                        state_q <= StScan;
                    end
                end
                StScan: begin
                    dout_q       <= mem_q[ch_q][rd_idx];
                    dout_tap_q   <= cnt_q;
                    dout_ch_q    <= ch_q;
                    dout_valid_q <= 1'b1;
                    dout_last_q  <= (cnt_q == TW'(SCAN_LEN - 1));
`ifdef FIR_TAP_BUFFER_SYM_EN
                    dout_mirror_q <= is_mid ? '0 : mem_q[ch_q][mr_idx];
`endif
                    cnt_q <= cnt_q + TW'(1);
                    if (cnt_q == TW'(SCAN_LEN - 1)) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tap_if.din_ready  = (state_q == StIdle);
    assign tap_if.dout       = dout_q;
    assign tap_if.dout_tap   = dout_tap_q;
    assign tap_if.dout_ch    = dout_ch_q;
    assign tap_if.dout_valid = dout_valid_q;
    assign tap_if.dout_last  = dout_last_q;

endmodule

// File: tb/tb_fir_tap_buffer.sv
// Directed bench for fir_tap_buffer: scan contents, timing, channel isolation, drops and reset.
module tb_fir_tap_buffer;
    localparam int NC  = 17;
    localparam int NCH = 3;
    localparam int CW  = 2;
    localparam int TW  = 5;
`ifdef FIR_TAP_BUFFER_SYM_EN
    localparam int SL = (NC + 1) / 2;
`else
    localparam int SL = NC;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir_tap_buffer_if #(.WIN(16), .NUM_COEF(NC), .NUM_CH(NCH)) bus_if ();

    fir_tap_buffer #(.WIN(16), .NUM_COEF(NC), .NUM_CH(NCH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .tap_if (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference history: hist[c][k] is x[n-k] of channel c.
    logic [15:0] hist [NCH][NC];

    logic        cap_valid [SL];
    logic [15:0] cap_dout  [SL];
    logic [15:0] cap_mir   [SL];
    logic [TW-1:0] cap_tap [SL];
    logic [CW-1:0] cap_ch  [SL];
    logic        cap_last  [SL];
    logic        cap_ready [SL];
    logic        pre_valid, pre_ready;
    time         t_acc;

    function automatic logic [15:0] model_tap(int c, int k);
        return hist[c][k];
    endfunction

    function automatic logic [15:0] exp_mir(int c, int k);
`ifdef FIR_TAP_BUFFER_SYM_EN
        if ((NC % 2) == 1 && k == NC / 2) return 16'h0000;
        return hist[c][NC-1-k];
`else
        return (c < 0 || k < 0) ? 16'hxxxx : 16'h0000;
`endif
    endfunction

    task automatic model_push(input int c, input logic [15:0] v);
        for (int k = NC - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = v;
    endtask

    task automatic model_clear();
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < NC; k++) hist[c][k] = 16'h0000;
    endtask

    // Called at a negedge; returns after the accepting posedge (+1).
    task automatic send(input int ch, input logic [15:0] v, output bit ok);
        ok = 1'b0;
        bus_if.din       = v;
        bus_if.din_ch    = CW'(ch);
        bus_if.din_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus_if.din_ready === 1'b1) begin
                @(posedge clk);
                t_acc = $time;
                #1;
                bus_if.din_valid = 1'b0;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        bus_if.din_valid = 1'b0;
    endtask

    // Records the cycle after accept and every scan beat; ends at a negedge.
    task automatic capture();
        @(negedge clk);
        pre_valid = bus_if.dout_valid;
        pre_ready = bus_if.din_ready;
        for (int k = 0; k < SL; k++) begin
            @(posedge clk);
            @(negedge clk);
            cap_valid[k] = bus_if.dout_valid;
            cap_dout[k]  = bus_if.dout;
            cap_tap[k]   = bus_if.dout_tap;
            cap_ch[k]    = bus_if.dout_ch;
            cap_last[k]  = bus_if.dout_last;
            cap_ready[k] = bus_if.din_ready;
`ifdef FIR_TAP_BUFFER_SYM_EN
            cap_mir[k]   = bus_if.dout_mirror;
`else
            cap_mir[k]   = 16'h0000;
`endif
        end
    endtask

    task automatic do_scan(input int ch, input logic [15:0] v, output bit ok);
        send(ch, v, ok);
        if (ok) begin
            if (ch < NCH) model_push(ch, v);
            capture();
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        bus_if.din_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus_if.dout !== 16'h0000) begin
            n_fail++; $display("FAIL reset_dout: got %h want 0000", bus_if.dout);
        end
        n_checks++;
        if (bus_if.dout_tap !== 5'd0) begin
            n_fail++; $display("FAIL reset_tap: got %0d want 0", bus_if.dout_tap);
        end
        n_checks++;
        if (bus_if.dout_ch !== 2'd0) begin
            n_fail++; $display("FAIL reset_ch: got %0d want 0", bus_if.dout_ch);
        end
        n_checks++;
        if (bus_if.dout_valid !== 1'b0 || bus_if.dout_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid_last: got %b%b want 00", bus_if.dout_valid,
                     bus_if.dout_last);
        end
        n_checks++;
        if (bus_if.din_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", bus_if.din_ready);
        end
    endtask

    task automatic test_single();
        bit ok;
        logic [15:0] e;
        do_scan(0, 16'h0001, ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++; $display("FAIL single_accept: got %b want 1", ok);
        end
        n_checks++;
        if (pre_ready !== 1'b0 || pre_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_pre: got ready=%b valid=%b want 0 0", pre_ready,
                               pre_valid);
        end
        for (int k = 0; k < SL; k++) begin
            e = (k == 0) ? 16'h0001 : 16'h0000;
            n_checks++;
            if (cap_valid[k] !== 1'b1 || cap_dout[k] !== e || cap_tap[k] !== TW'(k) ||
                cap_ch[k] !== 2'd0 || cap_last[k] !== (k == SL - 1) ||
                cap_ready[k] !== (k == SL - 1) || cap_mir[k] !== 16'h0000) begin
                n_fail++;
                $display("FAIL single_beat %0d: got v=%b d=%h t=%0d c=%0d l=%b r=%b m=%h, want d=%h",
                         k, cap_valid[k], cap_dout[k], cap_tap[k], cap_ch[k], cap_last[k],
                         cap_ready[k], cap_mir[k], e);
            end
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus_if.dout_valid !== 1'b0 || bus_if.dout_last !== 1'b0 ||
            bus_if.dout !== 16'h0000 || bus_if.dout_tap !== TW'(SL - 1)) begin
            n_fail++;
            $display("FAIL idle_hold: got v=%b l=%b d=%h t=%0d want 0 0 0000 %0d",
                     bus_if.dout_valid, bus_if.dout_last, bus_if.dout, bus_if.dout_tap, SL - 1);
        end
    endtask

    task automatic test_back_to_back();
        bit  ok;
        time t_prev;
        t_prev = 0;
        for (int i = 1; i <= 20; i++) begin
            do_scan(0, 16'(i), ok);
            n_checks++;
            if (ok !== 1'b1) begin
                n_fail++; $display("FAIL b2b_accept %0d: got %b want 1", i, ok);
            end else begin
                if (i > 1) begin
                    n_checks++;
                    if (t_acc - t_prev !== time'((SL + 1) * 10)) begin
                        n_fail++;
                        $display("FAIL b2b_rate %0d: got %0t want %0d", i, t_acc - t_prev,
                                 (SL + 1) * 10);
                    end
                end
                t_prev = t_acc;
                n_checks++;
                if (cap_dout[0] !== 16'(i) || cap_valid[0] !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_tap0 %0d: got %h want %h", i, cap_dout[0], i);
                end
            end
        end
        for (int k = 0; k < SL; k++) begin
            n_checks++;
            if (cap_valid[k] !== 1'b1 || cap_dout[k] !== 16'(20 - k) ||
                cap_tap[k] !== TW'(k) || cap_last[k] !== (k == SL - 1) ||
                cap_mir[k] !== exp_mir(0, k)) begin
                n_fail++;
                $display("FAIL b2b_beat %0d: got v=%b d=%h t=%0d l=%b m=%h want d=%h m=%h", k,
                         cap_valid[k], cap_dout[k], cap_tap[k], cap_last[k], cap_mir[k],
                         16'(20 - k), exp_mir(0, k));
            end
        end
    endtask

    task automatic test_interleave();
        bit ok;
        int ch;
        apply_reset();
        for (int n = 0; n < 20; n++) begin
            ch = n % 2;
            do_scan(ch, (ch == 0 ? 16'h1000 : 16'h2000) + 16'(n / 2), ok);
            n_checks++;
            if (ok !== 1'b1) begin
                n_fail++; $display("FAIL ilv_accept %0d: got %b want 1", n, ok);
            end else begin
                for (int k = 0; k < SL; k++) begin
                    n_checks++;
                    if (cap_valid[k] !== 1'b1 || cap_dout[k] !== model_tap(ch, k) ||
                        cap_ch[k] !== CW'(ch) || cap_tap[k] !== TW'(k) ||
                        cap_mir[k] !== exp_mir(ch, k)) begin
                        n_fail++;
                        $display("FAIL ilv_beat n%0d k%0d: got v=%b d=%h c=%0d m=%h want d=%h c=%0d",
                                 n, k, cap_valid[k], cap_dout[k], cap_ch[k], cap_mir[k],
                                 model_tap(ch, k), ch);
                    end
                end
            end
        end
    endtask

    task automatic test_extremes();
        bit ok;
        int chs [4];
        logic [15:0] vals [4];
        chs  = '{0, 1, 0, 1};
        vals = '{16'h8000, 16'h7FFF, 16'h0004, 16'h0005};
        for (int n = 0; n < 4; n++) begin
            if (n == 2) begin
                // Invalid channel: consumed without a scan or any history change.
                send(3, 16'h5555, ok);
                n_checks++;
                if (ok !== 1'b1) begin
                    n_fail++; $display("FAIL drop_accept: got %b want 1", ok);
                end
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    n_checks++;
                    if (bus_if.dout_valid !== 1'b0 || bus_if.din_ready !== 1'b1) begin
                        n_fail++;
                        $display("FAIL drop_idle %0d: got valid=%b ready=%b want 0 1", c,
                                 bus_if.dout_valid, bus_if.din_ready);
                    end
                end
            end
            do_scan(chs[n], vals[n], ok);
            n_checks++;
            if (ok !== 1'b1) begin
                n_fail++; $display("FAIL ext_accept %0d: got %b want 1", n, ok);
            end else begin
                for (int k = 0; k < SL; k++) begin
                    n_checks++;
                    if (cap_valid[k] !== 1'b1 || cap_dout[k] !== model_tap(chs[n], k) ||
                        cap_ch[k] !== CW'(chs[n]) || cap_mir[k] !== exp_mir(chs[n], k)) begin
                        n_fail++;
                        $display("FAIL ext_beat n%0d k%0d: got v=%b d=%h c=%0d m=%h want d=%h m=%h",
                                 n, k, cap_valid[k], cap_dout[k], cap_ch[k], cap_mir[k],
                                 model_tap(chs[n], k), exp_mir(chs[n], k));
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        bit ok;
        logic [15:0] e;
        send(0, 16'h00AA, ok);
        @(negedge clk);
        for (int k = 0; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_checks++;
        if (bus_if.dout_valid !== 1'b1 || bus_if.dout_tap !== 5'd5) begin
            n_fail++; $display("FAIL mid_pre: got valid=%b tap=%0d want 1 5", bus_if.dout_valid,
                               bus_if.dout_tap);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus_if.dout_valid !== 1'b0 || bus_if.dout_last !== 1'b0) begin
            n_fail++; $display("FAIL mid_async: got valid=%b last=%b want 0 0", bus_if.dout_valid,
                               bus_if.dout_last);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        for (int n = 0; n < 2; n++) begin
            e = (n == 0) ? 16'h0003 : 16'h0006;
            do_scan(n, e, ok);
            n_checks++;
            if (ok !== 1'b1) begin
                n_fail++; $display("FAIL mid_accept %0d: got %b want 1", n, ok);
            end else begin
                for (int k = 0; k < SL; k++) begin
                    n_checks++;
                    if (cap_valid[k] !== 1'b1 || cap_dout[k] !== ((k == 0) ? e : 16'h0000) ||
                        cap_mir[k] !== 16'h0000) begin
                        n_fail++;
                        $display("FAIL mid_beat ch%0d k%0d: got v=%b d=%h m=%h want d=%h m=0000",
                                 n, k, cap_valid[k], cap_dout[k], cap_mir[k],
                                 (k == 0) ? e : 16'h0000);
                    end
                end
            end
        end
    endtask

`ifdef FIR_TAP_BUFFER_SYM_EN
    task automatic test_symmetric();
        bit ok;
        logic [15:0] ed, em;
        apply_reset();
        for (int i = 1; i <= 17; i++) do_scan(0, 16'(i), ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++; $display("FAIL sym_accept: got %b want 1", ok);
        end
        for (int k = 0; k < 9; k++) begin
            ed = 16'(17 - k);
            em = (k < 8) ? 16'(1 + k) : 16'h0000;
            n_checks++;
            if (cap_valid[k] !== 1'b1 || cap_dout[k] !== ed || cap_mir[k] !== em ||
                cap_last[k] !== (k == 8)) begin
                n_fail++;
                $display("FAIL sym_beat %0d: got v=%b d=%h m=%h l=%b want d=%h m=%h l=%b", k,
                         cap_valid[k], cap_dout[k], cap_mir[k], cap_last[k], ed, em, k == 8);
            end
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.din       = '0;
        bus_if.din_ch    = '0;
        bus_if.din_valid = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_interleave();
        test_extremes();
        test_reset_mid_scan();
`ifdef FIR_TAP_BUFFER_SYM_EN
        test_symmetric();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
